// File: rtl/and_arb_pkg.sv
// Shared types and helpers for the round-robin AND arbiter.
// STAT_W sizes the optional per-requester grant counters
// (AND_RR_ARBITER_STATS_EN).
package and_arb_pkg;

    // Output register occupancy.
    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } and_arb_state_e;

    localparam int STAT_W  = 16;
    // rr_pick works on a fixed-width request vector; callers zero-extend.
    localparam int MAX_REQ = 32;
    localparam int IDX_W   = 5;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req[m-1:0], scanning upward from ptr and wrapping
    // modulo m. ptr must be below m.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input int ptr,
                                         input int m);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= m) idx = idx - m;
            if (k < m && !r.found && req[idx[IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = idx[IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/and_stage.sv
// Registered bitwise AND with load enable. Cleared to zero by reset.
module and_stage #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] c_o
);

    logic [N-1:0] c_q;

    // Capture a & b whenever a new operand pair is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
        end else if (en_i) begin
            c_q <= a_i & b_i;
        end
    end

    assign c_o = c_q;

endmodule

// File: rtl/and_rr_arbiter.sv
// One registered AND unit shared by M requesters through a round-robin
// arbiter, with a single tagged valid/ready result channel.
//
// Handshake: a transfer happens on an edge where valid and ready are both
// high; ready never depends on valid of the same channel's own beat
// except through arbitration, and a producer must hold its payload while
// valid is high and ready is low.
//
// Optional feature: define AND_RR_ARBITER_STATS_EN to add grant_cnt, one
// saturating 16-bit grant counter per requester.
module and_rr_arbiter
    import and_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [M-1:0]         req_valid,
    output logic [M-1:0]         req_ready,
    input  logic [M*N-1:0]       req_a,
    input  logic [M*N-1:0]       req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [N-1:0]         rsp_c,
    output logic [$clog2(M)-1:0] rsp_id
`ifdef AND_RR_ARBITER_STATS_EN
    ,
    output logic [M*STAT_W-1:0]  grant_cnt
`endif
);

    localparam int IDW = $clog2(M);

    and_arb_state_e state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] rsp_id_q;
    logic [IDW-1:0] grant_idx;
    rr_pick_t       pick;
    logic           accept;
    logic           xfer;
    logic [N-1:0]   a_sel, b_sel;

    // Arbitration: pick the requester nearest to ptr and decide whether
    // the output register can take a new result this cycle.
    always_comb begin
        pick      = rr_pick(MAX_REQ'(req_valid), int'(ptr_q), M);
        grant_idx = pick.idx[IDW-1:0];
        accept    = (state_q == IDLE) || rsp_ready;
        // rst_n gating keeps every ready low while reset is held.
        xfer      = rst_n && accept && pick.found;
        a_sel     = req_a[grant_idx*N +: N];
        b_sel     = req_b[grant_idx*N +: N];
        for (int i = 0; i < M; i++) begin
            req_ready[i] = xfer && (grant_idx == IDW'(i));
        end
    end

    // Next state for occupancy and the round-robin pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            state_d = FULL;
            ptr_d   = (grant_idx == IDW'(M - 1)) ? '0 : grant_idx + IDW'(1);
        end else if (state_q == FULL && rsp_ready) begin
            state_d = IDLE;
        end
    end

    // Occupancy, pointer and result tag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            rsp_id_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (xfer) begin
                rsp_id_q <= grant_idx;
            end
        end
    end

    and_stage #(.N(N)) u_and_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (xfer),
        .a_i   (a_sel),
        .b_i   (b_sel),
        .c_o   (rsp_c)
    );

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = rsp_id_q;

`ifdef AND_RR_ARBITER_STATS_EN
    logic [STAT_W-1:0] cnt_q [M];

    for (genvar gi = 0; gi < M; gi++) begin : g_stats
        // Count grants to this requester, sticking at all-ones.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[gi] <= '0;
            end else if (xfer && grant_idx == IDW'(gi) && cnt_q[gi] != '1) begin
                cnt_q[gi] <= cnt_q[gi] + STAT_W'(1);
            end
        end
        assign grant_cnt[gi*STAT_W +: STAT_W] = cnt_q[gi];
    end
`endif

endmodule

// File: tb/tb_and_rr_arbiter.sv
// Randomized and directed bench for and_rr_arbiter (N=4, M=2), checked
// against a transaction-level reference model and a result queue.
module tb_and_rr_arbiter;

  localparam int N   = 4;
  localparam int M   = 2;
  localparam int IDW = $clog2(M);
  localparam int W   = IDW + N;

  logic           clk;
  logic           rst_n;
  logic [M-1:0]   req_valid;
  logic [M-1:0]   req_ready;
  logic [M*N-1:0] req_a;
  logic [M*N-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [N-1:0]   rsp_c;
  logic [IDW-1:0] rsp_id;
`ifdef AND_RR_ARBITER_STATS_EN
  logic [M*16-1:0] grant_cnt;
`endif

  and_rr_arbiter #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .rsp_id    (rsp_id)
`ifdef AND_RR_ARBITER_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_total;
  int n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int           m_ptr;
  bit           m_full;
  logic [N-1:0] m_c;
  int           m_id;
  logic [M-1:0] m_last_grant;
  int           m_cnt [M];
  logic [W-1:0] exp_q[$];

  task automatic model_reset();
    m_ptr = 0;
    m_full = 0;
    m_c = '0;
    m_id = 0;
    m_last_grant = '0;
    for (int i = 0; i < M; i++) m_cnt[i] = 0;
    exp_q.delete();
  endtask

  // One full clock cycle, entered just after a falling edge: drive inputs,
  // check the combinational grant, retire a result on the consumer side,
  // advance the model at the rising edge, check outputs at the next fall.
  task automatic run_cycle(input logic [M-1:0] v, input logic [M*N-1:0] a,
                           input logic [M*N-1:0] b, input logic rr);
    bit           found;
    int           g;
    int           idx;
    bit           take;
    logic [M-1:0] exp_ready;
    logic [N-1:0] ga, gb;
    logic [W-1:0] front;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    #1;
    found = 0;
    g = 0;
    for (int k = 0; k < M; k++) begin
      idx = (m_ptr + k) % M;
      if (!found && v[idx]) begin
        found = 1;
        g = idx;
      end
    end
    take = found && (!m_full || rr);
    exp_ready = '0;
    if (take) exp_ready[g] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    if (rsp_valid && rr) begin
      if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
      else begin
        front = exp_q.pop_front();
        check("pop_result", {rsp_id, rsp_c}, front);
      end
    end
    @(posedge clk);
    m_last_grant = exp_ready;
    if (take) begin
      ga = a[g*N +: N];
      gb = b[g*N +: N];
      m_full = 1;
      m_c = ga & gb;
      m_id = g;
      m_ptr = (g + 1) % M;
      if (m_cnt[g] < 65535) m_cnt[g]++;
      exp_q.push_back({IDW'(g), m_c});
    end else if (m_full && rr) begin
      m_full = 0;
    end
    @(negedge clk);
    check("rsp_valid", rsp_valid, m_full);
    check("rsp_c", rsp_c, m_c);
    check("rsp_id", rsp_id, m_id);
  endtask

  // ---------------- stimulus ----------------
  logic [M-1:0]   rv;
  logic [M*N-1:0] ra, rb;

  initial begin
    n_total = 0;
    n_pass = 0;
    model_reset();
    rst_n = 1'b0;
    req_valid = '1;
    req_a = '1;
    req_b = '1;
    rsp_ready = 1'b1;

    // Reset: outputs clear and no ready even with requests present.
    #2;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_c", rsp_c, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_req_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;

    // Idle after reset.
    repeat (3) run_cycle('0, '0, '0, 1'b1);

    // Single request from requester 0: 1111 & 1010.
    run_cycle(2'b01, {4'b0000, 4'b1111}, {4'b0000, 4'b1010}, 1'b1);
    check("single_c", rsp_c, 4'b1010);

    // Backpressure while FULL with both requesters waiting.
    repeat (3) run_cycle(2'b11, {4'b0011, 4'b1100}, {4'b1111, 4'b1111}, 1'b0);
    check("bp_hold_c", rsp_c, 4'b1010);

    // Contention at full throughput: ids alternate.
    repeat (5) run_cycle(2'b11, {4'b0011, 4'b1100}, {4'b1111, 4'b1111}, 1'b1);

    // Drain, then leave the pointer at 1 before a mid-operation reset.
    run_cycle('0, '0, '0, 1'b1);
    run_cycle(2'b01, {4'b0000, 4'b0110}, {4'b0000, 4'b1111}, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_c", rsp_c, 0);
    check("midrst_req_ready", req_ready, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_cycle(2'b11, {4'b0101, 4'b1001}, {4'b1111, 4'b1111}, 1'b1);
    check("midrst_first_id", rsp_id, 0);

    // Randomized traffic; stalled requesters keep their payload.
    rv = '0;
    ra = '0;
    rb = '0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < M; i++) begin
        if (!(rv[i] && !m_last_grant[i])) begin
          rv[i] = ($urandom_range(0, 2) != 0);
          ra[i*N +: N] = N'($urandom);
          rb[i*N +: N] = N'($urandom);
        end
      end
      run_cycle(rv, ra, rb, ($urandom_range(0, 3) != 0));
    end

    // Drain what is left.
    for (int t = 0; t < 4; t++) run_cycle('0, '0, '0, 1'b1);
    check("queue_empty", exp_q.size(), 0);

`ifdef AND_RR_ARBITER_STATS_EN
    for (int i = 0; i < M; i++) check("grant_cnt", grant_cnt[i*16 +: 16], m_cnt[i]);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
